// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
//   BP_ADDR_W   : storage width of the tag and target fields in a BTB entry.
//   CTR_*       : 2-bit saturating counter states, strongly/weakly not-taken/taken.
//   btb_entry_t : one BTB entry as seen by lookup and update logic.
package branch_predictor_pkg;

  localparam int BP_ADDR_W = 32;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic [BP_ADDR_W-1:0] tag;
    logic [BP_ADDR_W-1:0] target;
    logic [1:0]           ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, next-value only (purely combinational).
//   i_ctr : current counter value
//   i_inc : 1 = count towards taken (+1, stops at 3), 0 = towards not-taken (-1, stops at 0)
//   o_ctr : next counter value
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_inc) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for the fetch stage.
// Ports:
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_flush               : invalidate every entry (fence.i)
//   i_stall               : hold the prediction registers, ignore the lookup
//   i_fetch_valid/_pc     : lookup request
//   o_pred_valid/_taken/_target : registered prediction for the last accepted lookup
//   i_upd_*               : training from execute (pc, direction, jump flag, target)
// Index = pc[IDX_W:1], tag = pc >> (IDX_W+1). Valid bits are reset flops; the
// tag/target/counter storage has no reset and maps onto distributed RAM.
// IADDR_SPACE_BITS must not exceed BP_ADDR_W.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IADDR_SPACE_BITS  = 32,
  parameter bit BRANCH_PREDICTION = 1'b1,
  parameter int BTB_ENTRIES       = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_flush,
  input  logic                        i_stall,
  input  logic                        i_fetch_valid,
  input  logic [IADDR_SPACE_BITS-1:0] i_fetch_pc,
  output logic                        o_pred_valid,
  output logic                        o_pred_taken,
  output logic [IADDR_SPACE_BITS-1:0] o_pred_target,
  input  logic                        i_upd_valid,
  input  logic [IADDR_SPACE_BITS-1:0] i_upd_pc,
  input  logic                        i_upd_taken,
  input  logic                        i_upd_jump,
  input  logic [IADDR_SPACE_BITS-1:0] i_upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  // Tag is everything above the index; bit 0 is ignored (RVC alignment).
  function automatic logic [BP_ADDR_W-1:0] tag_of(input logic [IADDR_SPACE_BITS-1:0] pc);
    return BP_ADDR_W'(pc >> (IDX_W + 1));
  endfunction

  logic [BP_ADDR_W-1:0] tag_mem    [BTB_ENTRIES];
  logic [BP_ADDR_W-1:0] target_mem [BTB_ENTRIES];
  logic [1:0]           ctr_mem    [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;

  logic [IDX_W-1:0] fetch_idx, upd_idx;
  btb_entry_t       fetch_ent, upd_ent;
  logic             fetch_hit, upd_hit;

  assign fetch_idx = i_fetch_pc[IDX_W:1];
  assign upd_idx   = i_upd_pc[IDX_W:1];

  // Asynchronous reads: lookup sees pre-update contents in a same-cycle update.
  always_comb begin
    fetch_ent.valid  = valid_q[fetch_idx];
    fetch_ent.tag    = tag_mem[fetch_idx];
    fetch_ent.target = target_mem[fetch_idx];
    fetch_ent.ctr    = ctr_mem[fetch_idx];
    upd_ent.valid    = valid_q[upd_idx];
    upd_ent.tag      = tag_mem[upd_idx];
    upd_ent.target   = target_mem[upd_idx];
    upd_ent.ctr      = ctr_mem[upd_idx];
  end

  assign fetch_hit = fetch_ent.valid && (fetch_ent.tag == tag_of(i_fetch_pc));
  assign upd_hit   = upd_ent.valid && (upd_ent.tag == tag_of(i_upd_pc));

  // ---------------- training ----------------
  logic [1:0]           ctr_next;
  logic                 upd_alloc;
  logic                 mem_we;
  logic [BP_ADDR_W-1:0] mem_wtarget;
  logic [1:0]           mem_wctr;

  sat_counter2 u_sat_counter2 (
    .i_ctr (upd_ent.ctr),
    .i_inc (i_upd_taken),
    .o_ctr (ctr_next)
  );

  // A flush in the same cycle swallows the update entirely.
  assign upd_alloc   = i_upd_valid && !i_flush && !upd_hit && i_upd_taken;
  assign mem_we      = i_upd_valid && !i_flush && (upd_hit || i_upd_taken);
  assign mem_wtarget = i_upd_taken ? BP_ADDR_W'(i_upd_target) : upd_ent.target;
  assign mem_wctr    = upd_hit ? ctr_next : (i_upd_jump ? CTR_ST : CTR_WT);

  // On a hit the tag is rewritten with its own value, keeping one write port.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      tag_mem[upd_idx]    <= tag_of(i_upd_pc);
      target_mem[upd_idx] <= mem_wtarget;
      ctr_mem[upd_idx]    <= mem_wctr;
    end
  end

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_valid
    always_comb begin
      valid_d[gi] = valid_q[gi];
      if (i_flush) valid_d[gi] = 1'b0;
      else if (upd_alloc && (upd_idx == IDX_W'(gi))) valid_d[gi] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) valid_q[gi] <= 1'b0;
      else         valid_q[gi] <= valid_d[gi];
    end
  end

  // ---------------- prediction registers ----------------
  logic                        pred_valid_q,  pred_valid_d;
  logic                        pred_taken_q,  pred_taken_d;
  logic [IADDR_SPACE_BITS-1:0] pred_target_q, pred_target_d;

  always_comb begin
    pred_valid_d  = pred_valid_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (!i_stall) begin
      pred_valid_d  = i_fetch_valid;
      // A flush in the lookup cycle forces not-taken but still answers.
      pred_taken_d  = i_fetch_valid && !i_flush && fetch_hit &&
                      (fetch_ent.ctr > CTR_WNT) && BRANCH_PREDICTION;
      pred_target_d = pred_taken_d ? fetch_ent.target[IADDR_SPACE_BITS-1:0]
                                   : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign o_pred_valid  = pred_valid_q;
  assign o_pred_taken  = pred_taken_q;
  assign o_pred_target = pred_target_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: one instance with prediction enabled, one with
// it disabled, both fed the same stimulus and compared to a table model.
module tb_branch_predictor;

  localparam int AW = 32;
  localparam int N  = 16;

  logic          i_clk = 1'b0;
  logic          i_reset, i_flush, i_stall, i_fetch_valid;
  logic          i_upd_valid, i_upd_taken, i_upd_jump;
  logic [AW-1:0] i_fetch_pc, i_upd_pc, i_upd_target;
  logic          pv, pt, pv_n, pt_n;
  logic [AW-1:0] ptgt, ptgt_n;

  always #5 i_clk = ~i_clk;

  branch_predictor #(.IADDR_SPACE_BITS(AW), .BRANCH_PREDICTION(1'b1), .BTB_ENTRIES(N)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_stall(i_stall),
    .i_fetch_valid(i_fetch_valid), .i_fetch_pc(i_fetch_pc),
    .o_pred_valid(pv), .o_pred_taken(pt), .o_pred_target(ptgt),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .i_upd_jump(i_upd_jump), .i_upd_target(i_upd_target));

  branch_predictor #(.IADDR_SPACE_BITS(AW), .BRANCH_PREDICTION(1'b0), .BTB_ENTRIES(N)) dut_nbp (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_stall(i_stall),
    .i_fetch_valid(i_fetch_valid), .i_fetch_pc(i_fetch_pc),
    .o_pred_valid(pv_n), .o_pred_taken(pt_n), .o_pred_target(ptgt_n),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .i_upd_jump(i_upd_jump), .i_upd_target(i_upd_target));

  // ---------------- reference model ----------------
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic        exp_v, exp_t;
  logic [31:0] exp_tgt;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 2) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (2 * N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    exp_v = 0; exp_t = 0; exp_tgt = '0;
  endtask

  // Drive one cycle, advance the model at the edge, return 1ns after it.
  task automatic step(input logic fv, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic uj, input logic [31:0] utgt,
                      input logic fl, input logic st);
    int li, ui;
    bit hit;
    i_fetch_valid = fv; i_fetch_pc = fpc; i_upd_valid = uv; i_upd_pc = upc;
    i_upd_taken = ut; i_upd_jump = uj; i_upd_target = utgt;
    i_flush = fl; i_stall = st;
    @(posedge i_clk);
    if (!st) begin
      if (!fv) begin
        exp_v = 0; exp_t = 0; exp_tgt = '0;
      end else begin
        li = idx_of(fpc);
        hit = m_valid[li] && (m_tag[li] == tag_of(fpc));
        exp_v = 1;
        exp_t = !fl && hit && (m_ctr[li] >= 2);
        exp_tgt = exp_t ? m_tgt[li] : '0;
      end
    end
    if (fl) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
    end else if (uv) begin
      ui = idx_of(upc);
      if (m_valid[ui] && m_tag[ui] == tag_of(upc)) begin
        if (ut) begin
          m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_tgt[ui] = utgt;
        end else begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[ui] = 1; m_tag[ui] = tag_of(upc); m_tgt[ui] = utgt;
        m_ctr[ui] = uj ? 3 : 2;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    i_flush = 0; i_stall = 0; i_fetch_valid = 0; i_fetch_pc = '0;
    i_upd_valid = 0; i_upd_pc = '0; i_upd_taken = 0; i_upd_jump = 0; i_upd_target = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    i_reset = 1;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({pv, pt, ptgt} !== {exp_v, exp_t, exp_tgt} || {pv_n, pt_n, ptgt_n} !== {exp_v, 1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL reset[%0d]: got v=%b t=%b tgt=%h nbp v=%b t=%b tgt=%h, expected v=%b t=%b tgt=%h",
                 k, pv, pt, ptgt, pv_n, pt_n, ptgt_n, exp_v, exp_t, exp_tgt);
      end else $display("reset[%0d] v=%b t=%b tgt=%h", k, pv, pt, ptgt);
    end
  endtask

  task automatic test_counter();
    for (int k = 0; k < 10; k++) begin
      case (k)
        0: step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        1: step(0, 0, 1, 32'h100, 1, 0, 32'h200, 0, 0);
        2: step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        3, 4, 6: step(0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
        5: step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        7: step(0, 0, 1, 32'h100, 1, 0, 32'h200, 0, 0);
        8: step(0, 0, 1, 32'h100, 1, 0, 32'h204, 0, 0);
        default: step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      endcase
      n_vec++;
      if ({pv, pt, ptgt} !== {exp_v, exp_t, exp_tgt} || {pv_n, pt_n, ptgt_n} !== {exp_v, 1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL counter[%0d]: got v=%b t=%b tgt=%h nbp v=%b t=%b tgt=%h, expected v=%b t=%b tgt=%h",
                 k, pv, pt, ptgt, pv_n, pt_n, ptgt_n, exp_v, exp_t, exp_tgt);
      end else $display("counter[%0d] v=%b t=%b tgt=%h", k, pv, pt, ptgt);
    end
  endtask

  task automatic test_alias();
    logic [31:0] alias_pc;
    alias_pc = 32'h100 + 2 * N;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: step(0, 0, 1, 32'h100, 1, 0, 32'h300, 0, 0);
        1: step(1, alias_pc, 0, 0, 0, 0, 0, 0, 0);
        2: step(0, 0, 1, alias_pc, 1, 1, 32'h400, 0, 0);
        3: step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        default: step(1, alias_pc, 0, 0, 0, 0, 0, 0, 0);
      endcase
      n_vec++;
      if ({pv, pt, ptgt} !== {exp_v, exp_t, exp_tgt} || {pv_n, pt_n, ptgt_n} !== {exp_v, 1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL alias[%0d]: got v=%b t=%b tgt=%h nbp v=%b t=%b tgt=%h, expected v=%b t=%b tgt=%h",
                 k, pv, pt, ptgt, pv_n, pt_n, ptgt_n, exp_v, exp_t, exp_tgt);
      end else $display("alias[%0d] v=%b t=%b tgt=%h", k, pv, pt, ptgt);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) step(1, 32'h140, 1, 32'h140, 1, 0, 32'h500, 0, 0);
      else        step(1, 32'h140, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({pv, pt, ptgt} !== {exp_v, exp_t, exp_tgt} || {pv_n, pt_n, ptgt_n} !== {exp_v, 1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL rbw[%0d]: got v=%b t=%b tgt=%h nbp v=%b t=%b tgt=%h, expected v=%b t=%b tgt=%h",
                 k, pv, pt, ptgt, pv_n, pt_n, ptgt_n, exp_v, exp_t, exp_tgt);
      end else $display("rbw[%0d] v=%b t=%b tgt=%h", k, pv, pt, ptgt);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 12; k++) begin
      if (k < 4)       step(0, 0, 1, 32'(2 * (k + 1)), 1, 1, 32'h1000 + 32'(4 * k), 0, 0);
      else if (k == 4) step(1, 32'h4, 0, 0, 0, 0, 0, 0, 0);
      else if (k == 5) step(1, 32'h6, 0, 0, 0, 0, 0, 1, 0);
      else if (k < 10) step(1, 32'(2 * (k - 5)), 0, 0, 0, 0, 0, 0, 0);
      else if (k == 10) step(0, 0, 1, 32'h2, 1, 1, 32'h2000, 1, 0);
      else             step(1, 32'h2, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({pv, pt, ptgt} !== {exp_v, exp_t, exp_tgt} || {pv_n, pt_n, ptgt_n} !== {exp_v, 1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL flush[%0d]: got v=%b t=%b tgt=%h nbp v=%b t=%b tgt=%h, expected v=%b t=%b tgt=%h",
                 k, pv, pt, ptgt, pv_n, pt_n, ptgt_n, exp_v, exp_t, exp_tgt);
      end else $display("flush[%0d] v=%b t=%b tgt=%h", k, pv, pt, ptgt);
    end
  endtask

  task automatic test_stall_reset();
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: step(0, 0, 1, 32'h80, 1, 1, 32'h900, 0, 0);
        1: step(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        2, 3, 4: step(k[0], 32'h100, 0, 0, 0, 0, 0, 0, 1);
        5: begin
          // Reset lands mid-cycle while stalled: outputs must drop with no edge.
          i_stall = 1; i_fetch_valid = 1; i_fetch_pc = 32'h80;
          @(negedge i_clk);
          i_reset = 1;
          #1 model_reset();
        end
        default: begin
          @(posedge i_clk);
          #1 i_reset = 0;
          step(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        end
      endcase
      n_vec++;
      if ({pv, pt, ptgt} !== {exp_v, exp_t, exp_tgt} || {pv_n, pt_n, ptgt_n} !== {exp_v, 1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL stall_reset[%0d]: got v=%b t=%b tgt=%h nbp v=%b t=%b tgt=%h, expected v=%b t=%b tgt=%h",
                 k, pv, pt, ptgt, pv_n, pt_n, ptgt_n, exp_v, exp_t, exp_tgt);
      end else $display("stall_reset[%0d] v=%b t=%b tgt=%h", k, pv, pt, ptgt);
    end
  endtask

  task automatic test_random();
    logic        fv, uv, ut, uj, fl, st;
    logic [31:0] fpc, upc, utgt;
    for (int k = 0; k < 300; k++) begin
      fv   = ($urandom_range(0, 9) < 8);
      fpc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 1);
      uv   = ($urandom_range(0, 1) == 1);
      upc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 1);
      uj   = ($urandom_range(0, 5) == 0);
      ut   = uj || ($urandom_range(0, 1) == 1);
      utgt = $urandom & 32'hFFFF_FFFE;
      fl   = ($urandom_range(0, 39) == 0);
      st   = ($urandom_range(0, 9) == 0);
      step(fv, fpc, uv, upc, ut, uj, utgt, fl, st);
      n_vec++;
      if ({pv, pt, ptgt} !== {exp_v, exp_t, exp_tgt} || {pv_n, pt_n, ptgt_n} !== {exp_v, 1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL random[%0d] pc=%h: got v=%b t=%b tgt=%h nbp v=%b t=%b tgt=%h, expected v=%b t=%b tgt=%h",
                 k, fpc, pv, pt, ptgt, pv_n, pt_n, ptgt_n, exp_v, exp_t, exp_tgt);
      end else $display("random[%0d] pc=%h v=%b t=%b tgt=%h", k, fpc, pv, pt, ptgt);
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_alias();
    test_back_to_back();
    test_flush();
    test_stall_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
